mem_access: RTL and testbench
=============================

# mem_access

Memory-access stage of the RV32I core, directly downstream of `execute`. It takes the ALU result (an effective address for loads and stores, the final result otherwise) and rs2 store data. It performs loads and stores on a single-outstanding, request/acknowledge data bus and hands a registered result to writeback. Misaligned accesses, bus errors and bus timeouts are reported as exceptions instead of being retired as normal writes.

## Interface
- `BUS_TIMEOUT`, default 255: cycles `dmem_req` may stay high without `dmem_ack` before an access fault is raised; legal range 1–65535.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous reset, active-low (0 = reset).
- `in_valid` in 1: the instruction from `execute` is valid.
- `in_ready` out 1: the stage accepts the instruction this cycle.
- `mem_op` in 4: [3] mem_en, [2] store, [1] unsigned (loads), [0] unused. Size is separate.
- `mem_size` in 2: 00 byte, 01 half, 10 word, 11 illegal (treated as word).
- `alu_result` in 32: effective address, or the result to pass through.
- `rs2` in 32: store data.
- `rd_addr` in 5: destination register.
- `reg_we` in 1: the instruction writes rd.
- `wb_valid` out 1: one-cycle retire pulse to writeback.
- `wb_we` out 1: write rd.
- `wb_rd` out 5: destination register.
- `wb_data` out 32: write data.
- `exc_valid` out 1: one-cycle exception pulse. It is exclusive with `wb_valid`.
- `exc_cause` out 4: 4 load misaligned, 5 load fault, 6 store misaligned, 7 store fault.
- `exc_addr` out 32: faulting address.
- `dmem_req` out 1: bus request, held until ack or timeout.
- `dmem_we` out 1: store.
- `dmem_addr` out 32: word-aligned address, {addr[31:2], 2'b00}.
- `dmem_wstrb` out 4: byte strobes. Zero for loads.
- `dmem_wdata` out 32: lane-replicated store data.
- `dmem_ack` in 1: transfer complete.
- `dmem_err` in 1: bus error. Qualified only by `dmem_ack`.
- `dmem_rdata` in 32: load data, valid when `dmem_ack` is high.

## Operation
- FSM states: IDLE, BUSY.
- `in_ready` = (state == IDLE).
- An instruction is accepted when `in_valid && in_ready`.
- Accepted instruction with mem_en = 0: next cycle `wb_valid`=1, `wb_data`=alu_result, `wb_we`=reg_we && rd≠0. State stays IDLE.
- Accepted memory operation, misaligned (half with addr[0]=1, or word with addr[1:0]≠0):
  - No bus request is issued.
  - Next cycle `exc_valid`=1, cause 4 or 6, `exc_addr`=alu_result.
  - State stays IDLE.
- Accepted memory operation, aligned: go to BUSY. Latch address, size, sign, rd and we. Drive the bus signals from the registered copies.
- Store lanes:
  - SB: wdata={4{rs2[7:0]}}, wstrb=4'b0001<<addr[1:0].
  - SH: wdata={2{rs2[15:0]}}, wstrb=addr[1]?4'b1100:4'b0011.
  - SW: wdata=rs2, wstrb=4'b1111.
- Load extraction:
  - Byte lane = rdata[8*addr[1:0] +: 8]. Half lane = rdata[16*addr[1] +: 16].
  - Sign-extended when unsigned=0, zero-extended when unsigned=1.
- BUSY exits:
  - ack with err=0 → IDLE. Next cycle `wb_valid`=1. Loads: `wb_we`=latched we && rd≠0. Stores: `wb_we`=0.
  - ack with err=1 → IDLE. Next cycle `exc_valid`=1, cause 5 or 7. No write.
  - Timeout: the wait counter reaches BUS_TIMEOUT with no ack → `dmem_req` drops. Next cycle `exc_valid`, cause 5 or 7. State returns to IDLE.
- `dmem_ack` in IDLE (late or spurious) is ignored.
- `exc_valid` and `wb_valid` never assert in the same cycle.

## Timing
- Reset values: `in_ready`=0 while rst=0 and 1 after it; all other outputs 0; state IDLE; counter 0.
- Non-memory latency: 1 cycle (accept at T, `wb_valid` at T+1).
- Memory latency:
  - Accept at T; `dmem_req` is high from T+1.
  - Ack sampled at A ≥ T+1; `dmem_req` is low at A+1, and `wb_valid` or `exc_valid` pulses at A+1.
  - Minimum load/store latency is 2 cycles.
- Back-to-back: a new instruction can be accepted in the same cycle as the previous `wb_valid`, because state is IDLE in that cycle.
- The address, wdata, wstrb and we bus signals stay stable for the whole time `dmem_req` is high.
- Timeout: the counter increments each BUSY cycle with no ack. Fault when the count equals BUS_TIMEOUT, i.e. the request is high for exactly BUS_TIMEOUT cycles.
- Reset while BUSY: next edge state=IDLE, `dmem_req`=0, and the in-flight instruction is dropped with no wb or exc pulse.
- `wb_data`, `wb_rd` and `exc_addr` are don't-care when their valid is 0, but must stay registered (glitch-free).

## Test plan
- ADD result passthrough: alu_result=0x0000_1234, rd=5, reg_we=1 → next cycle wb_valid=1, wb_we=1, wb_data=0x1234, wb_rd=5. Repeat with rd=0 → wb_we=0.
- LB/LBU at 0x1003, rdata=0x80FF_FF7F, ack after 3 cycles:
  - Bus: dmem_addr=0x1000, wstrb=0.
  - LB → wb_data=0xFFFF_FF80. LBU → 0x0000_0080.
  - wb_valid exactly 1 cycle after ack.
- SH at 0x2002 with rs2=0xDEAD_BEEF → dmem_we=1, wstrb=1100, wdata=0xBEEF_BEEF. After ack: wb_valid=1, wb_we=0.
- LW at 0x3001 → no dmem_req; next cycle exc_valid=1, cause=4, exc_addr=0x3001. SW at 0x3002 → cause 6.
- Faults:
  - LW with ack+err → exc cause 5.
  - SW with BUS_TIMEOUT=4 and no ack → req high 4 cycles, then exc cause 7. A late ack 2 cycles later is ignored.
- rst=0 while BUSY → next cycle dmem_req=0, no wb or exc pulse. After release, in_ready=1 and a new LW completes normally.

Source files
------------

// File: rtl/mem_access_if.sv
// Data-bus bundle between the memory-access stage (master) and data memory (slave).
// Single outstanding request, completed by ack; err is meaningful only alongside ack.
interface mem_access_if;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_wstrb;
    logic [31:0] dmem_wdata;
    logic        dmem_ack;
    logic        dmem_err;
    logic [31:0] dmem_rdata;

    modport master (
        output dmem_req, dmem_we, dmem_addr, dmem_wstrb, dmem_wdata,
        input  dmem_ack, dmem_err, dmem_rdata
    );

    modport slave (
        input  dmem_req, dmem_we, dmem_addr, dmem_wstrb, dmem_wdata,
        output dmem_ack, dmem_err, dmem_rdata
    );
endinterface

// File: rtl/mem_access.sv
// RV32I memory-access stage: passes ALU results through, runs loads/stores on a
// single-outstanding req/ack bus, and reports misalignment, bus errors and timeouts.
module mem_access #(
    parameter int unsigned BUS_TIMEOUT = 255
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [3:0]          mem_op,
    input  logic [1:0]          mem_size,
    input  logic [31:0]         alu_result,
    input  logic [31:0]         rs2,
    input  logic [4:0]          rd_addr,
    input  logic                reg_we,
    output logic                wb_valid,
    output logic                wb_we,
    output logic [4:0]          wb_rd,
    output logic [31:0]         wb_data,
    output logic                exc_valid,
    output logic [3:0]          exc_cause,
    output logic [31:0]         exc_addr,
    mem_access_if.master        dmem
);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t      state_reg, state_next;
    logic [15:0] cnt_reg;
    logic [31:0] addr_reg;
    logic [1:0]  size_reg;
    logic        unsigned_reg;
    logic        store_reg;
    logic [4:0]  rd_reg;
    logic        we_reg;
    logic [31:0] wdata_reg;
    logic [3:0]  wstrb_reg;

    logic        wb_valid_reg, wb_valid_next;
    logic        wb_we_reg, wb_we_next;
    logic [4:0]  wb_rd_reg, wb_rd_next;
    logic [31:0] wb_data_reg, wb_data_next;
    logic        exc_valid_reg, exc_valid_next;
    logic [3:0]  exc_cause_reg, exc_cause_next;
    logic [31:0] exc_addr_reg, exc_addr_next;

    logic        accept, mem_en, is_store, misaligned, start_access;
    logic        busy, ack_ok, ack_err, timeout;
    logic [31:0] st_wdata, load_data;
    logic [3:0]  st_wstrb;
    logic [15:0] ld_half;
    logic [7:0]  ld_byte;
    logic [7:0]  rd_byte [4];
    logic        unused_op;

    assign unused_op    = mem_op[0];
    assign mem_en       = mem_op[3];
    assign is_store     = mem_op[2];
    assign in_ready     = (state_reg == IDLE) && rst;
    assign accept       = in_valid && in_ready;
    assign misaligned   = ((mem_size == 2'b01) && alu_result[0]) ||
                          (mem_size[1] && (alu_result[1:0] != 2'b00));
    assign start_access = accept && mem_en && !misaligned;

    assign busy    = (state_reg == BUSY);
    assign ack_ok  = busy && dmem.dmem_ack && !dmem.dmem_err;
    assign ack_err = busy && dmem.dmem_ack && dmem.dmem_err;
    // Fires on the BUS_TIMEOUT-th request cycle, so req is high exactly that long.
    assign timeout = busy && !dmem.dmem_ack &&
                     (({1'b0, cnt_reg} + 17'd1) == 17'(BUS_TIMEOUT));

    // Store lane placement from the incoming instruction; latched on accept.
    always_comb begin
        st_wdata = rs2;
        st_wstrb = 4'b1111;
        case (mem_size)
            2'b00: begin
                st_wdata = {4{rs2[7:0]}};
                st_wstrb = 4'b0001 << alu_result[1:0];
            end
            2'b01: begin
                st_wdata = {2{rs2[15:0]}};
                st_wstrb = alu_result[1] ? 4'b1100 : 4'b0011;
            end
            default: begin
                st_wdata = rs2;
                st_wstrb = 4'b1111;
            end
        endcase
    end

    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        assign rd_byte[gi] = dmem.dmem_rdata[8*gi +: 8];
    end

    assign ld_byte = rd_byte[addr_reg[1:0]];
    assign ld_half = addr_reg[1] ? dmem.dmem_rdata[31:16] : dmem.dmem_rdata[15:0];

    always_comb begin
        load_data = dmem.dmem_rdata;
        case (size_reg)
            2'b00:   load_data = {{24{ld_byte[7] & ~unsigned_reg}}, ld_byte};
            2'b01:   load_data = {{16{ld_half[15] & ~unsigned_reg}}, ld_half};
            default: load_data = dmem.dmem_rdata;
        endcase
    end

    assign dmem.dmem_req   = busy;
    assign dmem.dmem_we    = busy && store_reg;
    assign dmem.dmem_addr  = {addr_reg[31:2], 2'b00};
    assign dmem.dmem_wstrb = busy ? wstrb_reg : 4'b0000;
    assign dmem.dmem_wdata = wdata_reg;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg     <= IDLE;
            cnt_reg       <= '0;
            addr_reg      <= '0;
            size_reg      <= '0;
            unsigned_reg  <= 1'b0;
            store_reg     <= 1'b0;
            rd_reg        <= '0;
            we_reg        <= 1'b0;
            wdata_reg     <= '0;
            wstrb_reg     <= '0;
            wb_valid_reg  <= 1'b0;
            wb_we_reg     <= 1'b0;
            wb_rd_reg     <= '0;
            wb_data_reg   <= '0;
            exc_valid_reg <= 1'b0;
            exc_cause_reg <= '0;
            exc_addr_reg  <= '0;
        end else begin
            state_reg     <= state_next;
            wb_valid_reg  <= wb_valid_next;
            wb_we_reg     <= wb_we_next;
            wb_rd_reg     <= wb_rd_next;
            wb_data_reg   <= wb_data_next;
            exc_valid_reg <= exc_valid_next;
            exc_cause_reg <= exc_cause_next;
            exc_addr_reg  <= exc_addr_next;
            cnt_reg       <= (busy && !dmem.dmem_ack) ? cnt_reg + 16'd1 : 16'd0;
            if (start_access) begin
                addr_reg     <= alu_result;
                size_reg     <= mem_size;
                unsigned_reg <= mem_op[1];
                store_reg    <= is_store;
                rd_reg       <= rd_addr;
                we_reg       <= reg_we;
                wdata_reg    <= st_wdata;
                wstrb_reg    <= is_store ? st_wstrb : 4'b0000;
            end
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (start_access) state_next = BUSY;
            BUSY:    if (dmem.dmem_ack || timeout) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Payload registers hold their value when no pulse is produced.
    always_comb begin
        wb_valid_next  = 1'b0;
        wb_we_next     = 1'b0;
        wb_rd_next     = wb_rd_reg;
        wb_data_next   = wb_data_reg;
        exc_valid_next = 1'b0;
        exc_cause_next = exc_cause_reg;
        exc_addr_next  = exc_addr_reg;
        if (accept && !mem_en) begin
            wb_valid_next = 1'b1;
            wb_we_next    = reg_we && (rd_addr != 5'd0);
            wb_rd_next    = rd_addr;
            wb_data_next  = alu_result;
        end else if (accept && misaligned) begin
            exc_valid_next = 1'b1;
            exc_cause_next = is_store ? 4'd6 : 4'd4;
            exc_addr_next  = alu_result;
        end else if (ack_ok) begin
            wb_valid_next = 1'b1;
            wb_we_next    = !store_reg && we_reg && (rd_reg != 5'd0);
            wb_rd_next    = rd_reg;
            wb_data_next  = store_reg ? wb_data_reg : load_data;
        end else if (ack_err || timeout) begin
            exc_valid_next = 1'b1;
            exc_cause_next = store_reg ? 4'd7 : 4'd5;
            exc_addr_next  = addr_reg;
        end
    end

    assign wb_valid  = wb_valid_reg;
    assign wb_we     = wb_we_reg;
    assign wb_rd     = wb_rd_reg;
    assign wb_data   = wb_data_reg;
    assign exc_valid = exc_valid_reg;
    assign exc_cause = exc_cause_reg;
    assign exc_addr  = exc_addr_reg;

endmodule

// File: tb/tb_mem_access.sv
// Directed bench for mem_access with BUS_TIMEOUT=4; memory side driven by hand.
module tb_mem_access;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  mem_op;
    logic [1:0]  mem_size;
    logic [31:0] alu_result;
    logic [31:0] rs2;
    logic [4:0]  rd_addr;
    logic        reg_we;
    logic        wb_valid;
    logic        wb_we;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        exc_valid;
    logic [3:0]  exc_cause;
    logic [31:0] exc_addr;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    mem_access_if bus ();

    mem_access #(.BUS_TIMEOUT(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .mem_op     (mem_op),
        .mem_size   (mem_size),
        .alu_result (alu_result),
        .rs2        (rs2),
        .rd_addr    (rd_addr),
        .reg_we     (reg_we),
        .wb_valid   (wb_valid),
        .wb_we      (wb_we),
        .wb_rd      (wb_rd),
        .wb_data    (wb_data),
        .exc_valid  (exc_valid),
        .exc_cause  (exc_cause),
        .exc_addr   (exc_addr),
        .dmem       (bus)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [3:0] op, input logic [1:0] sz, input logic [31:0] addr,
                         input logic [31:0] data, input logic [4:0] rd, input logic we);
        in_valid   = 1'b1;
        mem_op     = op;
        mem_size   = sz;
        alu_result = addr;
        rs2        = data;
        rd_addr    = rd;
        reg_we     = we;
    endtask

    // Accepted memory op acked (err=0) on its nreq-th request cycle.
    task automatic mem_txn(input string name, input logic [3:0] op, input logic [1:0] sz,
                           input logic [31:0] addr, input logic [31:0] data, input logic [4:0] rd,
                           input int nreq, input logic [31:0] rdata, input logic [3:0] exp_strb,
                           input logic [31:0] exp_wdata, input logic [31:0] exp_data,
                           input logic exp_we);
        issue(op, sz, addr, data, rd, 1'b1);
        check({name, "_ready"}, 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        for (int i = 1; i <= nreq; i++) begin
            check({name, "_req"}, 32'(bus.dmem_req), 32'd1);
            check({name, "_addr"}, bus.dmem_addr, {addr[31:2], 2'b00});
            check({name, "_strb"}, 32'(bus.dmem_wstrb), 32'(exp_strb));
            check({name, "_dwe"}, 32'(bus.dmem_we), 32'(op[2]));
            if (op[2]) check({name, "_wdata"}, bus.dmem_wdata, exp_wdata);
            check({name, "_busy_nowb"}, 32'(wb_valid), 32'd0);
            if (i == nreq) begin
                bus.dmem_ack   = 1'b1;
                bus.dmem_rdata = rdata;
            end
            tick();
        end
        bus.dmem_ack   = 1'b0;
        bus.dmem_rdata = 32'h0;
        check({name, "_wbv"}, 32'(wb_valid), 32'd1);
        check({name, "_exc"}, 32'(exc_valid), 32'd0);
        check({name, "_req_drop"}, 32'(bus.dmem_req), 32'd0);
        check({name, "_wbwe"}, 32'(wb_we), 32'(exp_we));
        check({name, "_b2b_ready"}, 32'(in_ready), 32'd1);
        if (!op[2]) begin
            check({name, "_data"}, wb_data, exp_data);
            check({name, "_rd"}, 32'(wb_rd), 32'(rd));
        end
        $display("txn %s addr=0x%08h wb_data=0x%08h wb_we=%0d", name, addr, wb_data, wb_we);
        tick();
        check({name, "_pulse"}, 32'(wb_valid), 32'd0);
    endtask

    task automatic misaligned_txn(input string name, input logic [3:0] op, input logic [1:0] sz,
                                  input logic [31:0] addr, input logic [3:0] cause);
        issue(op, sz, addr, 32'h1111_2222, 5'd3, 1'b1);
        tick();
        in_valid = 1'b0;
        check({name, "_exc"}, 32'(exc_valid), 32'd1);
        check({name, "_cause"}, 32'(exc_cause), 32'(cause));
        check({name, "_eaddr"}, exc_addr, addr);
        check({name, "_noreq"}, 32'(bus.dmem_req), 32'd0);
        check({name, "_nowb"}, 32'(wb_valid), 32'd0);
        $display("txn %s addr=0x%08h exc_cause=%0d", name, addr, exc_cause);
        tick();
        check({name, "_pulse"}, 32'(exc_valid), 32'd0);
    endtask

    initial begin
        rst            = 1'b0;
        in_valid       = 1'b0;
        mem_op         = 4'h0;
        mem_size       = 2'b00;
        alu_result     = 32'h0;
        rs2            = 32'h0;
        rd_addr        = 5'd0;
        reg_we         = 1'b0;
        bus.dmem_ack   = 1'b0;
        bus.dmem_err   = 1'b0;
        bus.dmem_rdata = 32'h0;
        tick();
        tick();
        check("rst_ready", 32'(in_ready), 32'd0);
        check("rst_wbv", 32'(wb_valid), 32'd0);
        check("rst_exc", 32'(exc_valid), 32'd0);
        check("rst_req", 32'(bus.dmem_req), 32'd0);
        check("rst_strb", 32'(bus.dmem_wstrb), 32'd0);
        check("rst_wbdata", wb_data, 32'd0);
        rst = 1'b1;
        #1;
        check("rel_ready", 32'(in_ready), 32'd1);
        $display("txn reset released");

        issue(4'b0000, 2'b10, 32'h0000_1234, 32'h0, 5'd5, 1'b1);
        tick();
        in_valid = 1'b0;
        check("add_wbv", 32'(wb_valid), 32'd1);
        check("add_we", 32'(wb_we), 32'd1);
        check("add_data", wb_data, 32'h0000_1234);
        check("add_rd", 32'(wb_rd), 32'd5);
        check("add_exc", 32'(exc_valid), 32'd0);
        $display("txn ADD rd=5 wb_data=0x%08h", wb_data);
        issue(4'b0000, 2'b10, 32'h0000_1234, 32'h0, 5'd0, 1'b1);
        tick();
        in_valid = 1'b0;
        check("add0_wbv", 32'(wb_valid), 32'd1);
        check("add0_we", 32'(wb_we), 32'd0);
        $display("txn ADD rd=0 wb_we=%0d", wb_we);
        tick();
        check("add0_pulse", 32'(wb_valid), 32'd0);

        mem_txn("LB", 4'b1000, 2'b00, 32'h0000_1003, 32'h0, 5'd7, 3, 32'h80FF_FF7F,
                4'b0000, 32'h0, 32'hFFFF_FF80, 1'b1);
        mem_txn("LBU", 4'b1010, 2'b00, 32'h0000_1003, 32'h0, 5'd8, 3, 32'h80FF_FF7F,
                4'b0000, 32'h0, 32'h0000_0080, 1'b1);
        mem_txn("LH", 4'b1000, 2'b01, 32'h0000_1002, 32'h0, 5'd9, 1, 32'h80FF_FF7F,
                4'b0000, 32'h0, 32'hFFFF_80FF, 1'b1);
        mem_txn("SH", 4'b1100, 2'b01, 32'h0000_2002, 32'hDEAD_BEEF, 5'd0, 2, 32'h0,
                4'b1100, 32'hBEEF_BEEF, 32'h0, 1'b0);
        mem_txn("SB", 4'b1100, 2'b00, 32'h0000_5001, 32'h0000_00A5, 5'd0, 1, 32'h0,
                4'b0010, 32'hA5A5_A5A5, 32'h0, 1'b0);
        mem_txn("LW_rd0", 4'b1000, 2'b10, 32'h0000_4000, 32'h0, 5'd0, 1, 32'h1234_5678,
                4'b0000, 32'h0, 32'h1234_5678, 1'b0);

        misaligned_txn("LW_mis", 4'b1000, 2'b10, 32'h0000_3001, 4'd4);
        misaligned_txn("SW_mis", 4'b1100, 2'b10, 32'h0000_3002, 4'd6);
        misaligned_txn("LH_mis", 4'b1000, 2'b01, 32'h0000_3003, 4'd4);

        issue(4'b1000, 2'b10, 32'h0000_6000, 32'h0, 5'd4, 1'b1);
        tick();
        in_valid = 1'b0;
        check("err_req", 32'(bus.dmem_req), 32'd1);
        tick();
        bus.dmem_ack = 1'b1;
        bus.dmem_err = 1'b1;
        tick();
        bus.dmem_ack = 1'b0;
        bus.dmem_err = 1'b0;
        check("err_exc", 32'(exc_valid), 32'd1);
        check("err_cause", 32'(exc_cause), 32'd5);
        check("err_eaddr", exc_addr, 32'h0000_6000);
        check("err_nowb", 32'(wb_valid), 32'd0);
        check("err_req_drop", 32'(bus.dmem_req), 32'd0);
        $display("txn LW bus error exc_cause=%0d", exc_cause);
        tick();

        issue(4'b1100, 2'b10, 32'h0000_7000, 32'h0BAD_F00D, 5'd0, 1'b0);
        tick();
        in_valid = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            check("to_req_high", 32'(bus.dmem_req), 32'd1);
            check("to_no_exc", 32'(exc_valid), 32'd0);
            tick();
        end
        check("to_req_drop", 32'(bus.dmem_req), 32'd0);
        check("to_exc", 32'(exc_valid), 32'd1);
        check("to_cause", 32'(exc_cause), 32'd7);
        check("to_eaddr", exc_addr, 32'h0000_7000);
        check("to_nowb", 32'(wb_valid), 32'd0);
        $display("txn SW timeout exc_cause=%0d", exc_cause);
        tick();
        check("to_pulse", 32'(exc_valid), 32'd0);
        bus.dmem_ack = 1'b1;
        tick();
        bus.dmem_ack = 1'b0;
        check("late_ack_wb", 32'(wb_valid), 32'd0);
        check("late_ack_exc", 32'(exc_valid), 32'd0);
        check("late_ack_ready", 32'(in_ready), 32'd1);
        $display("txn late ack ignored");

        issue(4'b1000, 2'b10, 32'h0000_8000, 32'h0, 5'd6, 1'b1);
        tick();
        in_valid = 1'b0;
        check("rb_req", 32'(bus.dmem_req), 32'd1);
        rst = 1'b0;
        tick();
        check("rb_req_drop", 32'(bus.dmem_req), 32'd0);
        check("rb_wb", 32'(wb_valid), 32'd0);
        check("rb_exc", 32'(exc_valid), 32'd0);
        check("rb_ready_low", 32'(in_ready), 32'd0);
        rst = 1'b1;
        #1;
        check("rb_ready", 32'(in_ready), 32'd1);
        tick();
        check("rb_dropped_wb", 32'(wb_valid), 32'd0);
        check("rb_dropped_exc", 32'(exc_valid), 32'd0);
        $display("txn reset while busy");
        mem_txn("LW_post", 4'b1000, 2'b10, 32'h0000_4000, 32'h0, 5'd10, 2, 32'hCAFE_0123,
                4'b0000, 32'h0, 32'hCAFE_0123, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
